// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family (up-counter and down_timer).
//   state_t            : 2-bit counter state (IDLE, LOADED, RUN, DONE)
//   CNT_WIDTH_DEFAULT  : default bit width of count values
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage : counter_pkg

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// A value is loaded, decremented on each enabled cycle, and tc pulses in the
// cycle cnt_out first reads 0. All outputs are registered.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-low reset
//   load     in   load cnt_in (wins over enab)
//   enab     in   decrement enable
//   cnt_in   in   [WIDTH] start count
//   cnt_out  out  [WIDTH] current count
//   tc       out  terminal-count pulse
//   busy     out  state LOADED or RUN
//   done     out  state DONE (count exhausted, holding)
//
// Configuration
//   DOWN_TIMER_AUTO_RELOAD_EN : when defined, terminal count reloads the last
//   loaded value and keeps running (periodic tc); DONE is never entered and
//   done is tied low.
// -----------------------------------------------------------------------------
module down_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef struct packed {
        state_t           state;
        logic [WIDTH-1:0] cnt;
        logic             tc;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        logic [WIDTH-1:0] reload;
`endif
    } nxt_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_busy;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
`else
    logic             r_done;
`endif

    // Next-state / next-count for one non-reset edge.
    function automatic nxt_t f_next(
        input state_t           cur_state,
        input logic [WIDTH-1:0] cur_cnt,
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        input logic [WIDTH-1:0] cur_reload,
`endif
        input logic             i_load,
        input logic             i_enab,
        input logic [WIDTH-1:0] i_cnt_in
    );
        nxt_t n;
        n.state  = cur_state;
        n.cnt    = cur_cnt;
        n.tc     = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        n.reload = cur_reload;
`endif
        if (i_load) begin
            n.cnt    = i_cnt_in;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            n.reload = i_cnt_in;
`endif
            n.state  = (i_cnt_in != '0) ? S_LOADED : S_IDLE;
        end else if (i_enab && (cur_state == S_LOADED || cur_state == S_RUN)) begin
            // LOADED/RUN always hold a nonzero count, so no underflow here.
            if (cur_cnt == ONE) begin
                n.tc    = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                n.cnt   = cur_reload;
                n.state = S_RUN;
`else
                n.cnt   = '0;
                n.state = S_DONE;
`endif
            end else begin
                n.cnt   = cur_cnt - ONE;
                n.state = S_RUN;
            end
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        nxt_t n;
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            r_reload <= '0;
`else
            r_done   <= 1'b0;
`endif
        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            n = f_next(r_state, r_cnt, r_reload, load, enab, cnt_in);
            r_reload <= n.reload;
`else
            n = f_next(r_state, r_cnt, load, enab, cnt_in);
            r_done   <= (n.state == S_DONE);
`endif
            r_state  <= n.state;
            r_cnt    <= n.cnt;
            r_tc     <= n.tc;
            // Status flags decoded from the next state so they are flops.
            r_busy   <= (n.state == S_LOADED) || (n.state == S_RUN);
        end
    end

    assign cnt_out = r_cnt;
    assign tc      = r_tc;
    assign busy    = r_busy;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    assign done    = 1'b0;
`else
    assign done    = r_done;
`endif

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
// Directed self-checking bench for down_timer (WIDTH = 5). Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_down_timer;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         enab;
    logic [W-1:0] cnt_in;
    logic [W-1:0] cnt_out;
    logic         tc;
    logic         busy;
    logic         done;

    int passed = 0;
    int total  = 0;

    down_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .enab    (enab),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out),
        .tc      (tc),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Check all four outputs at once.
    task automatic chk_all(input string tag, input int c, input bit t, input bit b, input bit d);
        chk({tag, ".cnt"},  32'(cnt_out), 32'(c));
        chk({tag, ".tc"},   32'(tc),      32'(t));
        chk({tag, ".busy"}, 32'(busy),    32'(b));
        chk({tag, ".done"}, 32'(done),    32'(d));
    endtask

    initial begin
        // Reset dominates load.
        rst = 1'b0; load = 1'b1; enab = 1'b0; cnt_in = 5'd7;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);

        // Pause and priority.
        rst = 1'b1; load = 1'b1; cnt_in = 5'd5; enab = 1'b0;
        tick(); chk_all("p_load5", 5, 0, 1, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk_all("p_e1", 4, 0, 1, 0);
        enab = 1'b0;
        tick(); chk_all("p_e0a", 4, 0, 1, 0);
        tick(); chk_all("p_e0b", 4, 0, 1, 0);
        enab = 1'b1;
        tick(); chk_all("p_e1b", 3, 0, 1, 0);
        load = 1'b1; cnt_in = 5'd9;
        tick(); chk_all("p_ld_en", 9, 0, 1, 0);
        load = 1'b0; enab = 1'b0;
        tick(); chk_all("p_hold9", 9, 0, 1, 0);

        // Zero load: stays idle, enab ignored.
        load = 1'b1; cnt_in = 5'd0;
        tick(); chk_all("z_load", 0, 0, 0, 0);
        load = 1'b0; enab = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_all("z_enab", 0, 0, 0, 0);
        end

        // Reset mid-run.
        load = 1'b1; cnt_in = 5'd10; enab = 1'b0;
        tick(); chk_all("r_load10", 10, 0, 1, 0);
        load = 1'b0; enab = 1'b1;
        repeat (4) tick();
        chk_all("r_run6", 6, 0, 1, 0);
        rst = 1'b0; load = 1'b1; cnt_in = 5'd3;
        tick(); chk_all("r_reset", 0, 0, 0, 0);
        rst = 1'b1; load = 1'b0; enab = 1'b1;
        tick(); chk_all("r_after1", 0, 0, 0, 0);
        tick(); chk_all("r_after2", 0, 0, 0, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        // Periodic reload: load 2, enab held.
        load = 1'b1; cnt_in = 5'd2; enab = 1'b0;
        tick(); chk_all("a_load2", 2, 0, 1, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk_all("a_1", 1, 0, 1, 0);
        tick(); chk_all("a_2", 2, 1, 1, 0);
        tick(); chk_all("a_3", 1, 0, 1, 0);
        tick(); chk_all("a_4", 2, 1, 1, 0);
        tick(); chk_all("a_5", 1, 0, 1, 0);
        tick(); chk_all("a_6", 2, 1, 1, 0);
`else
        // One-shot: load 3, enab held.
        load = 1'b1; cnt_in = 5'd3; enab = 1'b0;
        tick(); chk_all("o_load3", 3, 0, 1, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk_all("o_2", 2, 0, 1, 0);
        tick(); chk_all("o_1", 1, 0, 1, 0);
        tick(); chk_all("o_0", 0, 1, 0, 1);
        tick(); chk_all("o_done1", 0, 0, 0, 1);
        tick(); chk_all("o_done2", 0, 0, 0, 1);

        // Load in the tc cycle.
        load = 1'b1; cnt_in = 5'd1; enab = 1'b0;
        tick(); chk_all("t_load1", 1, 0, 1, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk_all("t_tc", 0, 1, 0, 1);
        load = 1'b1; cnt_in = 5'd2;
        tick(); chk_all("t_reload", 2, 0, 1, 0);

        // Maximum count.
        load = 1'b1; cnt_in = 5'd31; enab = 1'b1;
        tick(); chk_all("m_load31", 31, 0, 1, 0);
        load = 1'b0;
        repeat (30) tick();
        chk_all("m_at1", 1, 0, 1, 0);
        tick(); chk_all("m_at0", 0, 1, 0, 1);
        tick(); chk_all("m_hold", 0, 0, 0, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_down_timer
